// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Imported by the controller top and its comparator.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_e;

  localparam int REG_W_DEF   = 5;
  localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Load-use comparator: the load in EX writes a register the ID instruction reads.
// x0 is never a real dependency.
module load_use_detect
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_W = REG_W_DEF
) (
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs2,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rd,
  output logic             hit
);

  logic rd_nz;
  logic m_rs1;
  logic m_rs2;

  assign rd_nz = |ex_rd;
  assign m_rs1 = (ex_rd == id_rs1);
  assign m_rs2 = id_uses_rs2 && (ex_rd == id_rs2);
  assign hit   = ex_memread && rd_nz && (m_rs1 || m_rs2);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use bubbles,
// branch squashing and data-memory waits with a bounded freeze.
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_W       = REG_W_DEF,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   arst_n,
  input  logic [REG_W-1:0]       id_rs1,
  input  logic [REG_W-1:0]       id_rs2,
  input  logic                   id_uses_rs2,
  input  logic                   ex_memread,
  input  logic [REG_W-1:0]       ex_rd,
  input  logic                   mem_branch_taken,
  input  logic                   mem_access,
  input  logic                   dmem_ready,
  input  logic                   perf_clr,
  output logic                   en_pc,
  output logic                   en_if_id,
  output logic                   en_id_ex,
  output logic                   en_ex_mem,
  output logic                   en_mem_wb,
  output logic                   flush_if_id,
  output logic                   flush_id_ex,
  output logic                   flush_ex_mem,
  output logic                   pc_sel_branch,
  output logic [STALL_CNT_W-1:0] stall_cnt,
  output logic                   timeout_err
);

  localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(MEM_TIMEOUT);

  state_e state_q, state_d;
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic timeout_err_q, timeout_err_d;

  logic lu_hit;
  logic in_wait;
  logic to_hit;
  logic freeze;
  logic do_br;
  logic do_lu;

  logic c_en_pc, c_en_if_id, c_en_id_ex;
  logic c_en_ex_mem, c_en_mem_wb;
  logic c_fl_if_id, c_fl_id_ex, c_fl_ex_mem;
  logic c_pc_sel;

  load_use_detect #(
    .REG_W(REG_W)
  ) u_lud (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs2 (id_uses_rs2),
    .ex_memread  (ex_memread),
    .ex_rd       (ex_rd),
    .hit         (lu_hit)
  );

  assign in_wait = (state_q == MEM_WAIT);
  assign to_hit  = in_wait && !dmem_ready
                && (wait_cnt_q == WCNT_MAX);

  // A timed-out wait releases exactly like a ready memory.
  assign freeze = in_wait ? (!dmem_ready && !to_hit)
                          : (mem_access && !dmem_ready);
  assign do_br  = !freeze && mem_branch_taken;
  assign do_lu  = !freeze && !mem_branch_taken
               && lu_hit && (state_q != LU_STALL);

  always_comb begin
    state_d     = RUN;
    wait_cnt_d  = '0;
    c_en_pc     = 1'b1;
    c_en_if_id  = 1'b1;
    c_en_id_ex  = 1'b1;
    c_en_ex_mem = 1'b1;
    c_en_mem_wb = 1'b1;
    c_fl_if_id  = 1'b0;
    c_fl_id_ex  = 1'b0;
    c_fl_ex_mem = 1'b0;
    c_pc_sel    = 1'b0;
    unique case (1'b1)
      freeze: begin
        state_d     = MEM_WAIT;
        wait_cnt_d  = in_wait ? wait_cnt_q + WCNT_W'(1)
                              : WCNT_W'(1);
        c_en_pc     = 1'b0;
        c_en_if_id  = 1'b0;
        c_en_id_ex  = 1'b0;
        c_en_ex_mem = 1'b0;
        c_en_mem_wb = 1'b0;
      end
      do_br: begin
        c_pc_sel    = 1'b1;
        c_fl_if_id  = 1'b1;
        c_fl_id_ex  = 1'b1;
        c_fl_ex_mem = 1'b1;
      end
      do_lu: begin
        state_d    = LU_STALL;
        c_en_pc    = 1'b0;
        c_en_if_id = 1'b0;
        c_fl_id_ex = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (perf_clr)
      stall_cnt_d = '0;
    else if (!c_en_pc && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
  end

  assign timeout_err_d = timeout_err_q || to_hit;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      stall_cnt_q   <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Controls are forced low for as long as reset is held.
  assign en_pc         = arst_n && c_en_pc;
  assign en_if_id      = arst_n && c_en_if_id;
  assign en_id_ex      = arst_n && c_en_id_ex;
  assign en_ex_mem     = arst_n && c_en_ex_mem;
  assign en_mem_wb     = arst_n && c_en_mem_wb;
  assign flush_if_id   = arst_n && c_fl_if_id;
  assign flush_id_ex   = arst_n && c_fl_id_ex;
  assign flush_ex_mem  = arst_n && c_fl_ex_mem;
  assign pc_sel_branch = arst_n && c_pc_sel;
  assign stall_cnt     = stall_cnt_q;
  assign timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with MEM_TIMEOUT=4.
// Control outputs are checked as {en x5, pc_sel, flush x3}.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       arst_n;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs2, ex_memread;
  logic       mem_branch_taken, mem_access;
  logic       dmem_ready, perf_clr;
  logic       en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb;
  logic       flush_if_id, flush_id_ex, flush_ex_mem;
  logic       pc_sel_branch;
  logic [15:0] stall_cnt;
  logic       timeout_err;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [8:0] ALL_EN = 9'b11111_0_000;
  localparam logic [8:0] FROZEN = 9'b00000_0_000;
  localparam logic [8:0] LU     = 9'b00111_0_010;
  localparam logic [8:0] BR     = 9'b11111_1_111;

  logic [8:0] ctl;
  assign ctl = {en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb,
                pc_sel_branch, flush_if_id, flush_id_ex, flush_ex_mem};

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .REG_W(5),
    .MEM_TIMEOUT(4)
  ) dut (
    .clk             (clk),
    .arst_n          (arst_n),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_uses_rs2     (id_uses_rs2),
    .ex_memread      (ex_memread),
    .ex_rd           (ex_rd),
    .mem_branch_taken(mem_branch_taken),
    .mem_access      (mem_access),
    .dmem_ready      (dmem_ready),
    .perf_clr        (perf_clr),
    .en_pc           (en_pc),
    .en_if_id        (en_if_id),
    .en_id_ex        (en_id_ex),
    .en_ex_mem       (en_ex_mem),
    .en_mem_wb       (en_mem_wb),
    .flush_if_id     (flush_if_id),
    .flush_id_ex     (flush_id_ex),
    .flush_ex_mem    (flush_ex_mem),
    .pc_sel_branch   (pc_sel_branch),
    .stall_cnt       (stall_cnt),
    .timeout_err     (timeout_err)
  );

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_uses_rs2 = 0; ex_memread = 0;
    mem_branch_taken = 0; mem_access = 0;
    dmem_ready = 0; perf_clr = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    arst_n = 0;
    mem_branch_taken = 1;
    #2;
    chk("rst_ctl", 16'(ctl), 16'(FROZEN));
    chk("rst_stall_cnt", stall_cnt, 16'd0);
    chk("rst_timeout", 16'(timeout_err), 16'd0);
    mem_branch_taken = 0;
    tick(); tick();
    arst_n = 1;
    #1 chk("run_idle", 16'(ctl), 16'(ALL_EN));

    // load-use on rs1
    ex_memread = 1; ex_rd = 5; id_rs1 = 5;
    #1 chk("lu_rs1", 16'(ctl), 16'(LU));
    tick();
    #1 chk("lu_masked", 16'(ctl), 16'(ALL_EN));
    chk("lu_stall_cnt", stall_cnt, 16'd1);
    tick();

    // false positives, then real rs2 hit
    ex_memread = 1; ex_rd = 0; id_rs1 = 0;
    #1 chk("x0_no_stall", 16'(ctl), 16'(ALL_EN));
    ex_rd = 7; id_rs1 = 3; id_rs2 = 7; id_uses_rs2 = 0;
    #1 chk("rs2_unused", 16'(ctl), 16'(ALL_EN));
    id_uses_rs2 = 1;
    #1 chk("lu_rs2", 16'(ctl), 16'(LU));
    tick();
    chk("lu_rs2_cnt", stall_cnt, 16'd2);
    idle();
    #1 chk("after_lu_rs2", 16'(ctl), 16'(ALL_EN));
    tick();

    // branch wins over load-use
    ex_memread = 1; ex_rd = 5; id_rs1 = 5; mem_branch_taken = 1;
    #1 chk("br_lu", 16'(ctl), 16'(BR));
    tick();
    chk("br_stall_cnt", stall_cnt, 16'd2);
    idle();
    #1 chk("after_br", 16'(ctl), 16'(ALL_EN));
    tick();

    // 3-cycle memory wait
    mem_access = 1; dmem_ready = 0;
    #1 chk("mw_c1", 16'(ctl), 16'(FROZEN));
    tick();
    chk("mw_c2", 16'(ctl), 16'(FROZEN));
    tick();
    chk("mw_c3", 16'(ctl), 16'(FROZEN));
    tick();
    dmem_ready = 1;
    #1 chk("mw_release", 16'(ctl), 16'(ALL_EN));
    tick();
    chk("mw_stall_cnt", stall_cnt, 16'd5);
    chk("mw_no_timeout", 16'(timeout_err), 16'd0);

    // ready access held: never stalls
    for (int i = 0; i < 4; i++) begin
      mem_access = 1; dmem_ready = 1;
      #1 chk("ready_access", 16'(ctl), 16'(ALL_EN));
      tick();
    end
    chk("ready_stall_cnt", stall_cnt, 16'd5);
    idle();
    tick();

    // timeout: frozen 4 cycles, released on the 5th
    mem_access = 1; dmem_ready = 0;
    #1 chk("to_c1", 16'(ctl), 16'(FROZEN));
    tick();
    chk("to_c2", 16'(ctl), 16'(FROZEN));
    tick();
    chk("to_c3", 16'(ctl), 16'(FROZEN));
    tick();
    chk("to_c4", 16'(ctl), 16'(FROZEN));
    tick();
    chk("to_release", 16'(ctl), 16'(ALL_EN));
    chk("to_err_before", 16'(timeout_err), 16'd0);
    tick();
    chk("to_err_set", 16'(timeout_err), 16'd1);
    chk("to_stall_cnt", stall_cnt, 16'd9);
    idle();
    #1 chk("to_after", 16'(ctl), 16'(ALL_EN));
    tick();
    chk("to_err_sticky", 16'(timeout_err), 16'd1);
    perf_clr = 1;
    tick();
    perf_clr = 0;
    chk("clr_stall_cnt", stall_cnt, 16'd0);
    chk("clr_keeps_err", 16'(timeout_err), 16'd1);

    // reset in the 2nd MEM_WAIT cycle
    mem_access = 1; dmem_ready = 0;
    tick();
    tick();
    chk("rw_frozen", 16'(ctl), 16'(FROZEN));
    chk("rw_stall_cnt", stall_cnt, 16'd2);
    arst_n = 0;
    #1 chk("rw_rst_ctl", 16'(ctl), 16'(FROZEN));
    chk("rw_rst_cnt", stall_cnt, 16'd0);
    chk("rw_rst_err", 16'(timeout_err), 16'd0);
    mem_access = 0;
    tick();
    arst_n = 1;
    #1 chk("rw_after_rst", 16'(ctl), 16'(ALL_EN));
    tick();
    chk("rw_run", 16'(ctl), 16'(ALL_EN));
    chk("rw_run_cnt", stall_cnt, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
